// File: rtl/trigger_dac_loader_pkg.sv
// Shared constants, FSM encoding and frame packing for the trigger DAC loader.
package trigger_dac_loader_pkg;
   localparam int NBITS = 10;
   localparam int FRAME_W = 16;
   localparam int CLK_DIV = 4;
   localparam int CS_HIGH = 4;
   localparam logic [3:0] CMD_PREFIX = 4'h3;
   localparam logic [NBITS-1:0] DEFAULT_CODE = 10'd512;
   localparam int PAD_W = FRAME_W - 4 - NBITS;

   typedef enum logic [1:0] {
      IDLE,
      START,
      SHIFT,
      CSHOLD
   } spi_state_t;

   function automatic logic [FRAME_W-1:0] make_frame(
      input logic [NBITS-1:0] code
   );
      return {CMD_PREFIX, code, {PAD_W{1'b0}}};
   endfunction
endpackage

// File: rtl/trigger_dac_loader_if.sv
// Command strobes in, committed code, status and DAC pins out.
interface trigger_dac_loader_if;
   import trigger_dac_loader_pkg::*;

   logic             setTriggerV;
   logic             setTriggerV_1;
   logic             setTriggerV_0;
   logic             resetTrigV;
   logic [NBITS-1:0] trigVoltage;
   logic [3:0]       bitCount;
   logic             busy;
   logic             loadDone;
   logic             dacCsN;
   logic             dacSclk;
   logic             dacMosi;

   modport slave (
      input  setTriggerV, setTriggerV_1, setTriggerV_0, resetTrigV,
      output trigVoltage, bitCount, busy, loadDone,
      output dacCsN, dacSclk, dacMosi
   );

   modport master (
      output setTriggerV, setTriggerV_1, setTriggerV_0, resetTrigV,
      input  trigVoltage, bitCount, busy, loadDone,
      input  dacCsN, dacSclk, dacMosi
   );
endinterface

// File: rtl/trigger_dac_loader_spi_frame_tx.sv
// SPI mode-0 frame engine: CS setup, FRAME_W clocked bits, CS high hold.
module spi_frame_tx
   import trigger_dac_loader_pkg::*;
#(
   parameter int FW = FRAME_W,
   parameter int DIV = CLK_DIV,
   parameter int HOLD = CS_HIGH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [FW-1:0] frame,
   output logic          busy,
   output logic          done,
   output logic          cs_n,
   output logic          sclk,
   output logic          mosi
);
   localparam int CMAX = (DIV > HOLD) ? DIV : HOLD;
   localparam int CW = $clog2(CMAX + 1);
   localparam int BW = $clog2(FW + 1);

   spi_state_t    state, state_nx;
   logic [CW-1:0] cnt;
   logic [BW-1:0] edges;
   logic [FW-1:0] sreg;
   logic          sclk_q;
   logic          tick, hold_end, last;

   assign tick = cnt == CW'(DIV - 1);
   assign hold_end = cnt == CW'(HOLD - 1);
   assign last = edges == BW'(FW - 1);
   assign sclk = sclk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (start) state_nx = START;
         START:  if (tick) state_nx = SHIFT;
         SHIFT:  if (tick && sclk_q && last) state_nx = CSHOLD;
         CSHOLD: if (hold_end) state_nx = IDLE;
      endcase
   end

   always_comb begin
      cs_n = 1'b1;
      mosi = 1'b0;
      done = 1'b0;
      busy = state != IDLE;
      unique case (state)
         IDLE:   ;
         START,
         SHIFT: begin
            cs_n = 1'b0;
            mosi = sreg[FW-1];
         end
         CSHOLD: done = cnt == '0;
      endcase
   end

   // The final falling edge coincides with the move to CSHOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         edges <= '0;
         sreg <= '0;
         sclk_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               edges <= '0;
               sclk_q <= 1'b0;
               if (start) sreg <= frame;
            end
            START: cnt <= tick ? '0 : cnt + 1'b1;
            SHIFT: begin
               if (tick) begin
                  cnt <= '0;
                  sclk_q <= ~sclk_q;
                  if (sclk_q) begin
                     sreg <= {sreg[FW-2:0], 1'b0};
                     edges <= edges + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CSHOLD: begin
               cnt <= hold_end ? '0 : cnt + 1'b1;
               sclk_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/trigger_dac_loader.sv
// Collects MSB-first trigger-voltage bit strobes and writes commits to the DAC.
module trigger_dac_loader
   import trigger_dac_loader_pkg::*;
(
   input logic clk,
   input logic rst_n,
   trigger_dac_loader_if.slave bus
);
   logic [NBITS-1:0]   shift_reg, pend_code, trig_q;
   logic [FRAME_W-1:0] frame;
   logic [3:0]         bit_cnt;
   logic pending, tx_busy, start, strobe, full, discard;
   logic done, cs_n, sclk, mosi;

   assign strobe = bus.setTriggerV_1 | bus.setTriggerV_0;
   assign full = bit_cnt == 4'(NBITS);
   assign discard = bus.resetTrigV | ~(bus.setTriggerV | strobe);
   assign start = pending & ~tx_busy;
   assign frame = make_frame(pend_code);

   // A commit always re-arms pending, even on the cycle a frame launches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_cnt <= '0;
         pend_code <= DEFAULT_CODE;
         trig_q <= DEFAULT_CODE;
         pending <= 1'b1;
      end else begin
         if (full) begin
            pend_code <= shift_reg;
            trig_q <= shift_reg;
         end
         if (discard) begin
            shift_reg <= '0;
            bit_cnt <= '0;
         end else if (strobe) begin
            shift_reg <= {shift_reg[NBITS-2:0], bus.setTriggerV_1};
            bit_cnt <= full ? 4'd1 : bit_cnt + 4'd1;
         end else if (full) begin
            bit_cnt <= '0;
         end
         if (full) pending <= 1'b1;
         else if (start) pending <= 1'b0;
      end
   end

   spi_frame_tx #(
      .FW(FRAME_W),
      .DIV(CLK_DIV),
      .HOLD(CS_HIGH)
   ) u_tx (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .frame(frame),
      .busy(tx_busy),
      .done(done),
      .cs_n(cs_n),
      .sclk(sclk),
      .mosi(mosi)
   );

   assign bus.trigVoltage = trig_q;
   assign bus.bitCount = bit_cnt;
   assign bus.busy = tx_busy | pending;
   assign bus.loadDone = done;
   assign bus.dacCsN = cs_n;
   assign bus.dacSclk = sclk;
   assign bus.dacMosi = mosi;
endmodule

// File: tb/tb_trigger_dac_loader.sv
// Bench for trigger_dac_loader: directed scenarios plus random entries vs a model.
module tb_trigger_dac_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int passes = 0;

   trigger_dac_loader_if bus();

   trigger_dac_loader dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                    name, act, exp, $time);
   endtask

   // Reference model state
   bit         m_q[$];
   logic [9:0] m_trig, m_pend;
   bit         m_pending, have_prev;
   int         m_hold, m_wait, cap_bits, low_run, high_run;
   int         frames = 0;
   logic       prev_cs, prev_sclk;
   logic [15:0] cap, exp_frame, last_frame;

   always @(negedge clk) begin
      logic cs, fell, rose, stb;
      int code;
      if (!rst_n) begin
         m_q.delete();
         m_trig = 10'd512;
         m_pend = 10'd512;
         m_pending = 1;
         m_hold = 0;
         m_wait = 0;
         prev_cs = 1'b1;
         prev_sclk = 1'b0;
         have_prev = 0;
         cap_bits = 0;
         low_run = 0;
         high_run = 0;
         chk("rst_cs", bus.dacCsN, 1);
         chk("rst_sclk", bus.dacSclk, 0);
         chk("rst_mosi", bus.dacMosi, 0);
         chk("rst_done", bus.loadDone, 0);
         chk("rst_trig", bus.trigVoltage, 512);
         chk("rst_bitcount", bus.bitCount, 0);
         chk("rst_busy", bus.busy, 1);
      end else begin
         cs = bus.dacCsN;
         fell = prev_cs & ~cs;
         rose = ~prev_cs & cs;
         if (fell) begin
            chk("spurious_frame", m_pending, 1);
            if (have_prev) chk("cs_gap_ok", high_run >= 4, 1);
            exp_frame = {4'h3, m_pend, 2'b00};
            m_pending = 0;
            m_wait = 0;
            cap_bits = 0;
            cap = '0;
            low_run = 0;
         end
         if (m_q.size() == 10) begin
            code = 0;
            foreach (m_q[i]) code = code * 2 + int'(m_q[i]);
            m_trig = 10'(code);
            m_pend = 10'(code);
            m_pending = 1;
            m_q.delete();
         end
         stb = bus.setTriggerV_1 | bus.setTriggerV_0;
         if (bus.resetTrigV || !(bus.setTriggerV || stb)) m_q.delete();
         else if (stb) m_q.push_back(bus.setTriggerV_1);
         if (!cs && bus.dacSclk && !prev_sclk) begin
            cap = {cap[14:0], bus.dacMosi};
            cap_bits++;
         end
         if (cs) chk("sclk_idle", bus.dacSclk, 0);
         if (rose) begin
            chk("frame_bits", cap_bits, 16);
            chk("frame_data", cap, exp_frame);
            chk("cs_low_len", low_run, 132);
            last_frame = cap;
            frames++;
            m_hold = 4;
            high_run = 0;
            have_prev = 1;
         end
         if (cs) high_run++;
         else low_run++;
         if (cs && m_pending) begin
            m_wait++;
            chk("launch_latency", m_wait <= 5, 1);
         end
         chk("bitCount", bus.bitCount, m_q.size());
         chk("trigVoltage", bus.trigVoltage, m_trig);
         chk("loadDone", bus.loadDone, rose);
         chk("busy", bus.busy, m_pending || !cs || m_hold > 0);
         if (m_hold > 0) m_hold--;
         prev_cs = cs;
         prev_sclk = bus.dacSclk;
      end
   end

   task automatic drive(input logic stv, input logic d1, input logic d0,
                        input logic rt);
      @(negedge clk);
      #1;
      bus.setTriggerV = stv;
      bus.setTriggerV_1 = d1;
      bus.setTriggerV_0 = d0;
      bus.resetTrigV = rt;
   endtask

   task automatic strobe(input logic b, input logic both, input int gap);
      drive(1'b1, b | both, ~b | both, 1'b0);
      repeat (gap) drive(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic entry(input logic [9:0] code, input bit rnd);
      logic both;
      int gap;
      for (int i = 9; i >= 0; i--) begin
         both = rnd && code[i] && ($urandom_range(0, 3) == 0);
         gap = rnd ? int'($urandom_range(1, 3)) : 1;
         strobe(code[i], both, gap);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 3000);
      chk("idle_timeout", bus.busy, 0);
   endtask

   task automatic wait_cs_low();
      int n;
      n = 0;
      while (bus.dacCsN && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cs_low_timeout", bus.dacCsN, 0);
   endtask

   int r, k, f0;

   initial begin
      bus.setTriggerV = 1'b0;
      bus.setTriggerV_1 = 1'b0;
      bus.setTriggerV_0 = 1'b0;
      bus.resetTrigV = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      wait_idle();
      chk("t1_frame", last_frame, 16'h3800);
      chk("t1_frames", frames, 1);
      chk("t1_trig", bus.trigVoltage, 10'd512);

      entry(10'h2AA, 0);
      chk("t2_bitcount", bus.bitCount, 0);
      wait_idle();
      chk("t2_trig", bus.trigVoltage, 10'h2AA);
      chk("t2_frame", last_frame, 16'h3AA8);

      f0 = frames;
      strobe(1, 0, 1);
      strobe(0, 0, 1);
      strobe(1, 0, 1);
      strobe(1, 0, 1);
      chk("t3_partial", bus.bitCount, 4);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_cleared", bus.bitCount, 0);
      repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_noframe", frames, f0);
      chk("t3_trig", bus.trigVoltage, 10'h2AA);
      entry(10'h3FF, 0);
      wait_idle();
      chk("t3_frame", last_frame, 16'h3FFC);

      f0 = frames;
      entry(10'h155, 0);
      entry(10'h001, 0);
      entry(10'h002, 0);
      wait_idle();
      chk("t4_frames", frames, f0 + 2);
      chk("t4_frame", last_frame, 16'h3008);
      chk("t4_trig", bus.trigVoltage, 10'h002);

      repeat (6) strobe(0, 0, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      entry(10'h3FF, 0);
      wait_idle();
      chk("t5_trig", bus.trigVoltage, 10'h3FF);
      chk("t5_frame", last_frame, 16'h3FFC);

      entry(10'h0F0, 0);
      wait_cs_low();
      repeat (58) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_cs", bus.dacCsN, 1);
      chk("t6_sclk", bus.dacSclk, 0);
      chk("t6_mosi", bus.dacMosi, 0);
      chk("t6_trig", bus.trigVoltage, 10'd512);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_idle();
      chk("t6_frame", last_frame, 16'h3800);

      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: entry(10'($urandom_range(0, 1023)), 1);
            5: begin
               k = $urandom_range(1, 9);
               repeat (k) strobe($urandom_range(0, 1) == 1, 0, 1);
               if ($urandom_range(0, 1) == 1)
                  drive(1'b1, 1'b0, 1'b0, 1'b1);
               drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
            6: begin
               k = $urandom_range(0, 8);
               repeat (k) strobe($urandom_range(0, 1) == 1, 0, 1);
               drive(1'b1, 1'b1, 1'b0, 1'b1);
               entry(10'($urandom_range(0, 1023)), 1);
            end
            7: repeat ($urandom_range(1, 20))
                  drive(1'b0, 1'b0, 1'b0, 1'b0);
            8: wait_idle();
            default: begin
               k = $urandom_range(1, 8);
               repeat (k) strobe($urandom_range(0, 1) == 1, 0, 2);
               drive(1'b1, 1'b0, 1'b1, 1'b1);
               drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
         endcase
      end
      wait_idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
